acq_search_ctrl: RTL and testbench

Sequences the BeiDou B1I acquisition search around the correlator/energy datapath: it starts each coherent dwell, evaluates the returned energy against the detection threshold, and walks code phase then Doppler bin until a confirmed detection or the search space is exhausted. It issues the code-slip and code-reset pulses that drive the local code generator. Once lock is declared, no further code slips are generated until a new search is started.

---
 rtl/acq_search_ctrl.sv | 143 ++++++++++++++
 tb/tb_acq_search_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_search_ctrl.sv
// Acquisition search sequencer: walks code phase then Doppler bin, dwelling on
// each cell, confirming hits and tracking the strongest non-hit cell.
module acq_search_ctrl #(
  parameter int unsigned PHASE_STEPS = 4092,
  parameter int unsigned DOPP_BINS   = 21,
  parameter logic [49:0] THRESH      = 50'd19720000000,
  parameter int unsigned CONFIRM_N   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        result_ok,
  input  logic [49:0] energy,
  output logic        corr_start,
  output logic        code_slip,
  output logic        code_rst,
  output logic [11:0] phase_idx,
  output logic [4:0]  dopp_idx,
  output logic        busy,
  output logic        locked,
  output logic        fail,
  output logic [49:0] best_energy,
  output logic [11:0] best_phase,
  output logic [4:0]  best_dopp
);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_DWELL, S_CONFIRM, S_LOCKED, S_FAIL
  } state_t;

  localparam logic [11:0] PH_LAST  = 12'(PHASE_STEPS - 1);
  localparam logic [4:0]  DP_LAST  = 5'(DOPP_BINS - 1);
  localparam logic [2:0]  CONF_TGT = 3'(CONFIRM_N);

  state_t     state;
  logic       conf_pend;
  logic [2:0] conf_cnt;
  logic       hit;
  logic [2:0] cnt_next;

  always_comb begin
    hit      = (energy >= THRESH);
    cnt_next = (state == S_CONFIRM) ? conf_cnt + 3'd1 : 3'd1;
  end

  // Pulses default low every edge, so each one lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      conf_pend   <= 1'b0;
      conf_cnt    <= '0;
      corr_start  <= 1'b0;
      code_slip   <= 1'b0;
      code_rst    <= 1'b0;
      phase_idx   <= '0;
      dopp_idx    <= '0;
      busy        <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
      best_energy <= '0;
      best_phase  <= '0;
      best_dopp   <= '0;
    end else begin
      corr_start <= 1'b0;
      code_slip  <= 1'b0;
      code_rst   <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        conf_pend <= 1'b0;
        conf_cnt  <= '0;
        phase_idx <= '0;
        dopp_idx  <= '0;
        busy      <= 1'b0;
        locked    <= 1'b0;
        fail      <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_LOCKED, S_FAIL: begin
            if (start) begin
              state       <= S_STEP;
              conf_pend   <= 1'b0;
              conf_cnt    <= '0;
              code_rst    <= 1'b1;
              phase_idx   <= '0;
              dopp_idx    <= '0;
              busy        <= 1'b1;
              locked      <= 1'b0;
              fail        <= 1'b0;
              best_energy <= '0;
              best_phase  <= '0;
              best_dopp   <= '0;
            end
          end
          S_STEP: begin
            corr_start <= 1'b1;
            state      <= conf_pend ? S_CONFIRM : S_DWELL;
          end
          S_DWELL, S_CONFIRM: begin
            if (result_ok) begin
              if (hit) begin
                conf_cnt <= cnt_next;
                if (cnt_next == CONF_TGT) begin
                  state     <= S_LOCKED;
                  conf_pend <= 1'b0;
                  locked    <= 1'b1;
                  busy      <= 1'b0;
                end else begin
                  state     <= S_STEP;
                  conf_pend <= 1'b1;
                end
              end else begin
                conf_cnt  <= '0;
                conf_pend <= 1'b0;
                if (energy > best_energy) begin
                  best_energy <= energy;
                  best_phase  <= phase_idx;
                  best_dopp   <= dopp_idx;
                end
                if (phase_idx != PH_LAST) begin
                  phase_idx <= phase_idx + 12'd1;
                  code_slip <= 1'b1;
                  state     <= S_STEP;
                end else if (dopp_idx != DP_LAST) begin
                  phase_idx <= '0;
                  dopp_idx  <= dopp_idx + 5'd1;
                  code_rst  <= 1'b1;
                  state     <= S_STEP;
                end else begin
                  state <= S_FAIL;
                  fail  <= 1'b1;
                  busy  <= 1'b0;
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acq_search_ctrl.sv
// Directed bench for acq_search_ctrl: a driver answers each dwell from a vector
// list, a monitor checks the cell of every dwell against a scoreboard queue.
module tb_acq_search_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        result_ok = 1'b0;
  logic [49:0] energy = '0;
  logic        corr_start, code_slip, code_rst, busy, locked, fail;
  logic [11:0] phase_idx, best_phase;
  logic [4:0]  dopp_idx, best_dopp;
  logic [49:0] best_energy;

  acq_search_ctrl #(
    .PHASE_STEPS(8),
    .DOPP_BINS  (3),
    .THRESH     (50'd1000),
    .CONFIRM_N  (2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .result_ok(result_ok), .energy(energy),
    .corr_start(corr_start), .code_slip(code_slip), .code_rst(code_rst),
    .phase_idx(phase_idx), .dopp_idx(dopp_idx), .busy(busy),
    .locked(locked), .fail(fail), .best_energy(best_energy),
    .best_phase(best_phase), .best_dopp(best_dopp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] p;
    logic [4:0]  d;
    logic [49:0] e;
    bit          resp;
  } vec_t;

  typedef struct {
    logic [11:0] p;
    logic [4:0]  d;
  } cell_t;

  vec_t  vec[$];
  cell_t sb[$];
  cell_t mon_c;
  int unsigned n_pass = 0, n_total = 0;
  int unsigned slip_cnt = 0, rst_cnt = 0, dw_cnt = 0;
  int unsigned s0, r0, w0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every dwell start must land on the next expected cell.
  always @(negedge clk) begin
    if (code_slip) slip_cnt++;
    if (code_rst) rst_cnt++;
    if (corr_start) begin
      dw_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_dwell", 64'd1, 64'd0);
      end else begin
        mon_c = sb.pop_front();
        check("dwell_phase", 64'(phase_idx), 64'(mon_c.p));
        check("dwell_dopp", 64'(dopp_idx), 64'(mon_c.d));
      end
    end
  end

  task automatic add(input int p, input int d, input logic [49:0] e, input bit resp);
    vec_t t;
    t.p = 12'(p); t.d = 5'(d); t.e = e; t.resp = resp;
    vec.push_back(t);
  endtask

  task automatic play();
    vec_t  v;
    cell_t c;
    bit    seen;
    while (vec.size() > 0) begin
      v = vec.pop_front();
      c.p = v.p; c.d = v.d;
      sb.push_back(c);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (corr_start) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        check("dwell_timeout", 64'd0, 64'd1);
        sb.delete();
        vec.delete();
        return;
      end
      if (v.resp) begin
        result_ok = 1'b1;
        energy = v.e;
        @(negedge clk);
        result_ok = 1'b0;
      end
    end
  endtask

  task automatic snap();
    s0 = slip_cnt; r0 = rst_cnt; w0 = dw_cnt;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_code_rst", 64'(code_rst), 64'd1);
    check("start_locked_clr", 64'(locked), 64'd0);
    check("start_fail_clr", 64'(fail), 64'd0);
    check("start_phase", 64'(phase_idx), 64'd0);
    check("start_best_clr", 64'(best_energy), 64'd0);
  endtask

  initial begin
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_corr_start", 64'(corr_start), 64'd0);
    check("reset_best", 64'(best_energy), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep, all misses -> fail
    snap();
    do_start();
    for (int d = 0; d < 3; d++)
      for (int p = 0; p < 8; p++) add(p, d, 50'd10, 1'b1);
    play();
    check("sweep_fail", 64'(fail), 64'd1);
    check("sweep_busy", 64'(busy), 64'd0);
    check("sweep_slips", 64'(slip_cnt - s0), 64'd21);
    check("sweep_rsts", 64'(rst_cnt - r0), 64'd3);
    check("sweep_dwells", 64'(dw_cnt - w0), 64'd24);
    check("sweep_best_e", 64'(best_energy), 64'd10);

    // Equal maxima, strict compare keeps the first
    snap();
    do_start();
    for (int d = 0; d < 3; d++)
      for (int p = 0; p < 8; p++)
        add(p, d, ((p == 2 && d == 0) || (p == 6 && d == 2)) ? 50'd500 : 50'd100, 1'b1);
    play();
    check("tie_fail", 64'(fail), 64'd1);
    check("tie_best_e", 64'(best_energy), 64'd500);
    check("tie_best_phase", 64'(best_phase), 64'd2);
    check("tie_best_dopp", 64'(best_dopp), 64'd0);

    // Confirmed detection at (5,1)
    snap();
    do_start();
    for (int p = 0; p < 8; p++) add(p, 0, 50'd10, 1'b1);
    for (int p = 0; p < 5; p++) add(p, 1, 50'd10, 1'b1);
    add(5, 1, 50'd1000, 1'b1);
    add(5, 1, 50'd1000, 1'b1);
    play();
    check("lock_locked", 64'(locked), 64'd1);
    check("lock_busy", 64'(busy), 64'd0);
    check("lock_phase", 64'(phase_idx), 64'd5);
    check("lock_dopp", 64'(dopp_idx), 64'd1);
    check("lock_slips", 64'(slip_cnt - s0), 64'd12);
    check("lock_rsts", 64'(rst_cnt - r0), 64'd2);
    check("lock_dwells", 64'(dw_cnt - w0), 64'd15);
    snap();
    repeat (25) @(negedge clk);
    check("lock_hold_slips", 64'(slip_cnt - s0), 64'd0);
    check("lock_hold_dwells", 64'(dw_cnt - w0), 64'd0);
    check("lock_hold_locked", 64'(locked), 64'd1);

    // Hit not confirmed: search resumes at the next cell
    snap();
    do_start();
    add(0, 0, 50'd10, 1'b1);
    add(1, 0, 50'd10, 1'b1);
    add(2, 0, 50'd10, 1'b1);
    add(3, 0, 50'd1500, 1'b1);
    add(3, 0, 50'd900, 1'b1);
    add(4, 0, 50'd0, 1'b0);
    play();
    check("unconf_slips", 64'(slip_cnt - s0), 64'd4);
    check("unconf_rsts", 64'(rst_cnt - r0), 64'd1);
    check("unconf_best_e", 64'(best_energy), 64'd900);
    check("unconf_best_phase", 64'(best_phase), 64'd3);
    check("unconf_locked", 64'(locked), 64'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort1_busy", 64'(busy), 64'd0);

    // Abort with simultaneous result_ok at (4,1)
    do_start();
    for (int p = 0; p < 8; p++) add(p, 0, (p == 6) ? 50'd20 : 50'd10, 1'b1);
    for (int p = 0; p < 4; p++) add(p, 1, 50'd10, 1'b1);
    add(4, 1, 50'd0, 1'b0);
    play();
    result_ok = 1'b1;
    energy = 50'd900;
    abort = 1'b1;
    @(negedge clk);
    result_ok = 1'b0;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_corr_start", 64'(corr_start), 64'd0);
    check("abort_slip", 64'(code_slip), 64'd0);
    check("abort_rst", 64'(code_rst), 64'd0);
    check("abort_phase", 64'(phase_idx), 64'd0);
    check("abort_dopp", 64'(dopp_idx), 64'd0);
    check("abort_best_e", 64'(best_energy), 64'd20);
    check("abort_best_phase", 64'(best_phase), 64'd6);
    check("abort_best_dopp", 64'(best_dopp), 64'd0);
    snap();
    repeat (10) @(negedge clk);
    check("abort_idle_dwells", 64'(dw_cnt - w0), 64'd0);

    // Restart, then asynchronous reset mid-dwell
    do_start();
    add(0, 0, 50'd10, 1'b1);
    add(1, 0, 50'd0, 1'b0);
    play();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_corr_start", 64'(corr_start), 64'd0);
    check("arst_phase", 64'(phase_idx), 64'd0);
    check("arst_best", 64'(best_energy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    result_ok = 1'b1;
    energy = 50'd10;
    @(negedge clk);
    result_ok = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_dwells", 64'(dw_cnt - w0), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_best", 64'(best_energy), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
